// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter.
// PARITY is only reachable when the block is built with PISO_PARITY_EN.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int PISO_MIN_WIDTH = 2;
    localparam int PISO_MAX_WIDTH = 32;

    // Bits needed to index WIDTH frame positions (0..WIDTH-1).
    function automatic int piso_cnt_width(input int width);
        return (width <= PISO_MIN_WIDTH) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Up-counter that tracks the frame position of the bit currently on the line.
// Saturates at WIDTH-1 and flags that position on tc.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = piso_cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc    = (count_q == LAST);
    assign count = count_q;

    // clr wins over inc so a reload on the last bit restarts at position 0.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !tc) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// WIDTH-bit word to MSB-first serial stream with valid/ready upstream.
// Build with PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = piso_cnt_width(WIDTH);

    // Handshake: a word moves on a rising edge where din_valid && din_ready.
    // din_ready is combinational from state, is 0 throughout reset, and is high
    // in IDLE and on the cycle that drives the last bit of the current frame,
    // so consecutive frames follow each other with no gap. Upstream holds din
    // while din_ready is low; nothing is dropped.

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             so_q;
    logic             so_d;
    logic             so_valid_q;
    logic             so_valid_d;
    logic             frame_start_q;
    logic             frame_start_d;

    logic             load;
    logic             ready_int;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;
    logic [CW-1:0]    cnt;

`ifdef PISO_PARITY_EN
    logic par_q;
    logic par_d;

    always_comb begin
        par_d = par_q;
        if (load) begin
            par_d = ^din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt),
        .tc    (cnt_tc)
    );

    always_comb begin
        ready_int = 1'b0;
        case (state_q)
            IDLE:    ready_int = 1'b1;
`ifdef PISO_PARITY_EN
            PARITY:  ready_int = 1'b1;
`else
            SHIFT:   ready_int = cnt_tc;
`endif
            default: ready_int = 1'b0;
        endcase
    end

    assign din_ready = ready_int && !rst;
    assign load      = din_valid && din_ready;

    // Next-state and shift-register update.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    shreg_d = din;
                end
            end
            SHIFT: begin
                shreg_d = shreg_q << 1;
                if (cnt_tc) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    if (load) begin
                        shreg_d = din;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (load) begin
                    state_d = SHIFT;
                    shreg_d = din;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                shreg_d = '0;
            end
        endcase
    end

    // The counter holds the index of the bit on so; it parks at 0 outside SHIFT.
    always_comb begin
        cnt_clr = load || (state_d != SHIFT);
        cnt_inc = (state_q == SHIFT) && (state_d == SHIFT) && !load;
    end

    // Output registers take the value the line carries in the next cycle.
    always_comb begin
        so_d          = 1'b0;
        so_valid_d    = (state_d != IDLE);
        frame_start_d = load;
        case (state_d)
            SHIFT:   so_d = shreg_d[WIDTH-1];
`ifdef PISO_PARITY_EN
            PARITY:  so_d = par_q;
`endif
            default: so_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            so_q          <= 1'b0;
            so_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            so_q          <= so_d;
            so_valid_q    <= so_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign so          = so_q;
    assign so_valid    = so_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer at WIDTH=4; honours PISO_PARITY_EN.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         so;
  logic         so_valid;
  logic         frame_start;
  logic         busy;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .so          (so),
    .so_valid    (so_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  // ---------------- scoreboard state ----------------
  logic [1:0]   exp_q[$];   // {frame_start, so} per expected line bit
  logic [W-1:0] word_q[$];  // words the loopback receiver should rebuild
  int           n_checks = 0;
  int           n_pass   = 0;
  int           run_len  = 0;
  int           max_run  = 0;
  logic [W-1:0] rx;
  int           rx_cnt   = 0;
  logic [1:0]   e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- monitor + loopback receiver ----------------
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
      rx_cnt  = 0;
    end else begin
      chk("busy_vs_valid", busy, so_valid);
      if (so_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        chk("exp_available", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("so_bit", so, e[0]);
          chk("frame_start", frame_start, e[1]);
        end
        if (frame_start) rx_cnt = 0;
        if (rx_cnt < W) begin
          rx = {rx[W-2:0], so};
          rx_cnt++;
          if (rx_cnt == W) begin
            chk("word_available", word_q.size() != 0, 1);
            if (word_q.size() != 0) chk("loopback_word", rx, word_q.pop_front());
          end
        end
      end else begin
        run_len = 0;
        chk("idle_so", so, 0);
        chk("idle_frame_start", frame_start, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] w, output int waits);
    bit ok = 0;
    waits = 0;
    din       = w;
    din_valid = 1'b1;
    while (!ok && waits < 50) begin
      @(negedge clk);
      if (din_ready) ok = 1;
      else waits++;
    end
    chk("send_accept", ok, 1);
    if (ok) begin
      for (int k = 0; k < W; k++) exp_q.push_back({k == 0, w[W-1-k]});
`ifdef PISO_PARITY_EN
      exp_q.push_back({1'b0, ^w});
`endif
      word_q.push_back(w);
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_reached", t < 100, 1);
  endtask

  // ---------------- stimulus ----------------
  int           waits;
  logic [W-1:0] lb_words[5];

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_so", so, 0);
    chk("rst_so_valid", so_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_din_ready", din_ready, 0);
    rst = 1'b0;
    #1;
    chk("idle_din_ready", din_ready, 1);

    // single word 1011 -> 1,0,1,1
    send(4'b1011, waits);
    wait_idle();
    chk("after_single_ready", din_ready, 1);
    chk("after_single_so", so, 0);

    // back-to-back A then 5, so_valid continuous
    max_run = 0;
    send(4'hA, waits);
    send(4'h5, waits);
    chk("b2b_wait_cycles", waits, FRAME - 1);
    wait_idle();
    chk("b2b_valid_run", max_run, 2 * FRAME);

    // din changes mid-frame with valid low; frame unaffected
    send(4'hC, waits);
    din = 4'h3;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk("stall_ready", din_ready, k == FRAME - 1);
    end
    wait_idle();

    // reset during bit 2 of 4'hF
    send(4'hF, waits);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_so", so, 0);
    chk("midrst_so_valid", so_valid, 0);
    chk("midrst_frame_start", frame_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_din_ready", din_ready, 0);
    exp_q.delete();
    word_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(4'h9, waits);
    wait_idle();

    // loopback words back-to-back
    lb_words[0] = 4'h6;
    lb_words[1] = 4'hE;
    lb_words[2] = 4'h1;
    lb_words[3] = W'($urandom_range(0, 15));
    lb_words[4] = W'($urandom_range(0, 15));
    foreach (lb_words[i]) send(lb_words[i], waits);
    wait_idle();

`ifdef PISO_PARITY_EN
    // 0111 -> 0,1,1,1 then parity 1; ready only on the parity cycle
    send(4'b0111, waits);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk("parity_ready", din_ready, k == FRAME - 1);
    end
    wait_idle();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("word_q_drained", word_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter that converts a WIDTH-bit word into a serial bit stream, MSB first, one bit per clk.
- Serves as the transmit end of the team's serial-in/parallel-out link. The receiver shifts left and inserts at the LSB, so after WIDTH bits the word is reconstructed in its original bit order.
- Upstream side uses a valid/ready handshake. Downstream side gets so plus qualifying strobes.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block accepts din on this edge when din_valid is also high.
- so  output  1  serial data out, registered.
- so_valid  output  1  so carries a frame bit this cycle, registered.
- frame_start  output  1  one-cycle pulse coincident with the first (MSB) bit of each frame, registered.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset, asynchronous:
  - so=0, so_valid=0, frame_start=0, busy=0, state=IDLE, shift register=0, bit counter=0.
  - din_ready is forced to 0 while rst is high.
- Reset mid-frame: the partial frame is abandoned and outputs take reset values immediately. After rst deasserts, the next accepted word starts a fresh frame.
- FSM states: IDLE, SHIFT (plus PARITY when PARITY_EN is defined).
- Handshake:
  - Transfer occurs on a rising edge where din_valid && din_ready.
  - din_ready is combinational: 1 in IDLE, and 1 in SHIFT on the cycle that drives the last frame bit (bit counter == WIDTH-1, or the PARITY cycle when enabled). It is 0 otherwise.
- IDLE:
  - so=0, so_valid=0.
  - On transfer: load din into the shift register, counter=0, go to SHIFT.
- SHIFT:
  - so = shreg[WIDTH-1], so_valid=1. frame_start=1 only when counter==0.
  - Each cycle: shift left by one (zero fill) and increment the counter.
  - At counter==WIDTH-1: if a transfer occurs, reload and stay in SHIFT with counter=0. Otherwise go to IDLE (or to PARITY when enabled).
- Latency: word accepted at edge N, so bit din[WIDTH-1-k] is driven during the cycle following edge N+k, for k=0..WIDTH-1.
- Back-to-back frames have no idle gap, so so_valid stays continuously high.
- Throughput: one word per WIDTH cycles (WIDTH+1 with parity).
- din is sampled only at the transfer edge. Later changes to din do not affect the frame in flight.
- din_valid while not ready: the word is held upstream and nothing is lost.
- Counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one PARITY cycle drives so = even parity (XOR of the captured word), with so_valid=1.
  - Frame length is WIDTH+1. din_ready is high during the PARITY cycle instead of the last data cycle.
  - The parity bit is computed at load time and stored in one register.
- Undefined: no PARITY state, no parity register, frame length WIDTH.

Decomposition:
- Shared package piso_pkg: state enum typedef (IDLE, SHIFT, PARITY) and the localparam computing counter width from WIDTH.
- One natural sub-module: piso_bit_counter, a loadable up-counter with clear, increment and terminal-count output (tc when count==WIDTH-1).
- The FSM, shift register and output registers live in piso_serializer.

Test Plan (WIDTH=4):
- Single word: din=4'b1011, valid 1 cycle from IDLE -> so = 1,0,1,1 on the next 4 cycles; so_valid high for 4 cycles; frame_start high on the first only; then IDLE with so=0.
- Back-to-back: din_valid held high with 4'hA then 4'h5 -> din_ready pulses on the 4th bit cycle; so = 1,0,1,0,0,1,0,1 with so_valid continuous for 8 cycles; frame_start at cycles 1 and 5.
- Stall/din change: din=4'hC accepted, then din changed to 4'h3 with din_valid low mid-frame -> so = 1,1,0,0 unaffected; din_ready=0 on bit cycles 1-3.
- Reset mid-frame: rst pulsed during bit 2 of 4'hF -> so, so_valid, busy and frame_start drop to 0 asynchronously; next word 4'h9 is sent cleanly as 1,0,0,1.
- Loopback: so feeds the team's 4-bit SIPO receiver, random words -> receiver q equals the sent word after every 4th bit.
- PISO_PARITY_EN: din=4'b0111 -> so = 0,1,1,1 then parity 1; frame is 5 cycles; din_ready high on the parity cycle.
